// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: lit-high segment codes ({a,b,c,d,e,f,g}, a = bit 6)
// and the state encoding of the readback stability FSM.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse table: lit-high segment pattern to hex digit, with a hit flag
// that is low for any pattern the display encoder can never produce.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] lit,
    output logic       hit,
    output logic [3:0] digit
);

    always_comb begin
        hit   = 1'b1;
        digit = 4'h0;
        case (lit)
            SEG_0:   digit = 4'h0;
            SEG_1:   digit = 4'h1;
            SEG_2:   digit = 4'h2;
            SEG_3:   digit = 4'h3;
            SEG_4:   digit = 4'h4;
            SEG_5:   digit = 4'h5;
            SEG_6:   digit = 4'h6;
            SEG_7:   digit = 4'h7;
            SEG_8:   digit = 4'h8;
            SEG_9:   digit = 4'h9;
            SEG_A:   digit = 4'hA;
            SEG_B:   digit = 4'hB;
            SEG_C:   digit = 4'hC;
            SEG_D:   digit = 4'hD;
            SEG_E:   digit = 4'hE;
            SEG_F:   digit = 4'hF;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Seven-segment readback: synchronizes the segment lines, waits for a stable pattern,
// and offers the decoded digit on a valid/ready port with blank, error and drop reporting.
module seg7_readback_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             blank,
    output logic             pattern_err,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int               STB_W     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]       RAW_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0]       sync1_q, sync1_d;
    logic [6:0]       sync2_q, sync2_d;
    logic [6:0]       lit;
    logic [6:0]       lit_prev_q, lit_prev_d;
    logic [6:0]       last_acc_q, last_acc_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    seg7_state_t      state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             blank_q, blank_d;
    logic             pattern_err_q, pattern_err_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             accept;
    logic             lut_hit;
    logic [3:0]       lut_digit;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_norm
            assign lit[gi] = ACTIVE_LOW ? ~sync2_q[gi] : sync2_q[gi];
        end
    endgenerate

    seg7_pattern_lookup u_lookup (
        .lit   (lit),
        .hit   (lut_hit),
        .digit (lut_digit)
    );

    always_comb begin
        sync1_d       = seg_in;
        sync2_d       = sync1_q;
        lit_prev_d    = lit;
        last_acc_d    = last_acc_q;
        stb_cnt_d     = stb_cnt_q;
        state_d       = state_q;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
        blank_d       = blank_q;
        pattern_err_d = 1'b0;
        drop_cnt_d    = drop_cnt_q;
        accept        = 1'b0;

        // A cycle counts as stable only when lit matches the previous cycle's lit.
        case (state_q)
            ST_SETTLE: begin
                if (lit != lit_prev_q) begin
                    stb_cnt_d = '0;
                end else if (stb_cnt_q == STB_LAST) begin
                    stb_cnt_d = '0;
                    state_d   = ST_LOCKED;
                    accept    = (lit != last_acc_q);
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end
            ST_LOCKED: begin
                if (lit != lit_prev_q) begin
                    stb_cnt_d = '0;
                    state_d   = ST_SETTLE;
                end
            end
            default: begin
                stb_cnt_d = '0;
                state_d   = ST_SETTLE;
            end
        endcase

        if (digit_valid_q && digit_ready) begin
            digit_valid_d = 1'b0;
        end

        if (accept) begin
            last_acc_d = lit;
            if (lit == SEG_BLANK) begin
                blank_d = 1'b1;
            end else if (lut_hit) begin
                blank_d       = 1'b0;
                digit_d       = lut_digit;
                digit_valid_d = 1'b1;
                if (digit_valid_q && !digit_ready && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end else begin
                blank_d       = 1'b0;
                pattern_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= RAW_BLANK;
            sync2_q       <= RAW_BLANK;
            lit_prev_q    <= SEG_BLANK;
            last_acc_q    <= SEG_BLANK;
            stb_cnt_q     <= '0;
            state_q       <= ST_SETTLE;
            digit_q       <= 4'h0;
            digit_valid_q <= 1'b0;
            blank_q       <= 1'b1;
            pattern_err_q <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            lit_prev_q    <= lit_prev_d;
            last_acc_q    <= last_acc_d;
            stb_cnt_q     <= stb_cnt_d;
            state_q       <= state_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            blank_q       <= blank_d;
            pattern_err_q <= pattern_err_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign blank       = blank_q;
    assign pattern_err = pattern_err_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder (STABLE_CYCLES=4, common-anode lines).
module tb_seg7_readback_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       blank;
    logic       pattern_err;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] lit;
        logic [3:0] dig;
        logic       vld;
        logic       blk;
        logic       err;
    } vec_t;

    vec_t vecs[20];

    always #5 clk = ~clk;

    seg7_readback_decoder #(
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1'b1),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .blank       (blank),
        .pattern_err (pattern_err),
        .drop_cnt    (drop_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input int d, input int v, input int b,
                           input int e, input int dc);
        chk({tag, ".digit"}, int'(digit), d);
        chk({tag, ".valid"}, int'(digit_valid), v);
        chk({tag, ".blank"}, int'(blank), b);
        chk({tag, ".err"}, int'(pattern_err), e);
        chk({tag, ".drop"}, int'(drop_cnt), dc);
    endtask

    initial begin
        vecs[0]  = '{7'h30, 4'h1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{7'h01, 4'h1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{7'h00, 4'h1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{7'h7E, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{7'h6D, 4'h2, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{7'h79, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{7'h33, 4'h4, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{7'h5B, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{7'h5F, 4'h6, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{7'h70, 4'h7, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{7'h7F, 4'h8, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{7'h7B, 4'h9, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{7'h77, 4'hA, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{7'h1F, 4'hB, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{7'h4E, 4'hC, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{7'h3D, 4'hD, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{7'h4F, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{7'h47, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{7'h7C, 4'hF, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{7'h00, 4'hF, 1'b0, 1'b1, 1'b0};

        // Reset with all lines dark: reset values, then no event after release.
        rst_n       = 1'b0;
        seg_in      = 7'h7F;
        digit_ready = 1'b0;
        #12;
        chk_all("reset", 0, 0, 1, 0, 0);
        step(2);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(1);
            chk("idle.valid", int'(digit_valid), 0);
            chk("idle.err", int'(pattern_err), 0);
            chk("idle.blank", int'(blank), 1);
        end
        $display("txn reset/idle: digit=%0h valid=%0b blank=%0b", digit, digit_valid, blank);

        // Three-cycle glitch of "5" must not be accepted.
        seg_in = ~7'h5B;
        step(3);
        seg_in = 7'h7F;
        for (int c = 0; c < 12; c++) begin
            step(1);
            chk("glitch.valid", int'(digit_valid), 0);
            chk("glitch.err", int'(pattern_err), 0);
            chk("glitch.blank", int'(blank), 1);
        end
        $display("txn glitch: blank=%0b valid=%0b", blank, digit_valid);

        // Table: each pattern held with ready=1, result exactly on edge 7, handshake by edge 8.
        digit_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            seg_in = ~vecs[i].lit;
            step(6);
            chk("vec.pre_valid", int'(digit_valid), 0);
            chk("vec.pre_err", int'(pattern_err), 0);
            step(1);
            chk("vec.digit", int'(digit), int'(vecs[i].dig));
            chk("vec.valid", int'(digit_valid), int'(vecs[i].vld));
            chk("vec.blank", int'(blank), int'(vecs[i].blk));
            chk("vec.err", int'(pattern_err), int'(vecs[i].err));
            $display("txn vec%0d lit=%02h: digit=%0h valid=%0b blank=%0b err=%0b", i,
                     vecs[i].lit, digit, digit_valid, blank, pattern_err);
            step(1);
            chk("vec.post_valid", int'(digit_valid), 0);
            chk("vec.post_err", int'(pattern_err), 0);
            chk("vec.post_digit", int'(digit), int'(vecs[i].dig));
        end
        chk("vec.drop", int'(drop_cnt), 0);

        // Overwrite without consumer: 2 then 8 with ready=0.
        digit_ready = 1'b0;
        seg_in = ~7'h6D;
        step(7);
        chk_all("ovr.first", 2, 1, 0, 0, 0);
        seg_in = ~7'h7F;
        step(6);
        chk("ovr.hold_digit", int'(digit), 2);
        chk("ovr.hold_valid", int'(digit_valid), 1);
        step(1);
        chk_all("ovr.drop", 8, 1, 0, 0, 1);
        $display("txn overwrite: digit=%0h drop_cnt=%0d", digit, drop_cnt);

        // Overwrite with ready=1 on the loading edge: no drop counted.
        seg_in = ~7'h6D;
        step(6);
        chk("rdy.hold_digit", int'(digit), 8);
        digit_ready = 1'b1;
        step(1);
        chk_all("rdy.load", 2, 1, 0, 0, 1);
        digit_ready = 1'b0;
        step(1);
        chk("rdy.pending", int'(digit_valid), 1);
        chk("rdy.pending_digit", int'(digit), 2);
        $display("txn overwrite-ready: digit=%0h drop_cnt=%0d", digit, drop_cnt);

        // Reset mid-settle while "7" is held; re-emitted 7 edges after release.
        seg_in = ~7'h70;
        step(3);
        rst_n = 1'b0;
        #1;
        chk_all("midrst", 0, 0, 1, 0, 0);
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("rel.pre_valid", int'(digit_valid), 0);
        chk("rel.pre_blank", int'(blank), 1);
        step(1);
        chk_all("rel.emit", 7, 1, 0, 0, 0);
        $display("txn reset-release: digit=%0h valid=%0b", digit, digit_valid);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
